adder_tree_arbiter: RTL and testbench
=====================================

// Module: adder_tree_arbiter
// PURPOSE
//   Shares one 28-term, 5-level pipelined fixed-point adder tree (input 28x26b + 26b beta) among NREQ requesters.
//   Round-robin grant, at most one vector per cycle into the tree.
//   Tracks valid + requester ID alongside the tree latency, so each sum returns tagged to its owner.
//   Sits between the neuron/MAC units and the adder tree instance.
// PARAMETERS
//   NREQ      4    number of requesters (2..8)
//   DW        26   fixed-point word width
//   NTERMS    28   terms per vector
//   TREE_LAT  10   clk cycles from tree input to tree_sum valid (5 levels x (FF + registered adder))
//   IDW       2    requester-ID width, = clog2(NREQ)
// PORTS
//   clk          in   1             clock, rising edge
//   GlobalReset  in   1             asynchronous reset, active-high
//   req_valid    in   NREQ          requester i has a vector pending
//   req_ready    out  NREQ          one-hot grant; handshake completes when valid&ready
//   req_vec      in   NREQ*NTERMS*DW  flattened vectors, requester i at [i*NTERMS*DW +: NTERMS*DW]
//   req_beta     in   NREQ*DW       per-requester bias
//   sched_hold   in   1             1 = issue no new grants (in-flight sums still drain)
//   tree_vec     out  NTERMS*DW     to adder tree Result_28 input
//   tree_beta    out  DW            to adder tree Beta input
//   tree_sum     in   DW            from adder tree output
//   res_valid    out  1             tagged result strobe, one cycle
//   res_id       out  IDW           owner of res_data
//   res_data     out  DW            sum, equal to tree_sum on the res_valid cycle
//   busy         out  1             any sum in flight
// BEHAVIOUR
//   Reset: req_ready=0, tree_vec=0, tree_beta=0, res_valid=0, res_id=0, res_data=0, busy=0.
//     RR pointer=0, tag pipe cleared. Reset mid-operation drops all in-flight sums; no res_valid follows.
//   Grant (combinational from registered pointer): if !sched_hold, search req_valid from ptr upward, modulo NREQ.
//     First set bit gets req_ready. At most one bit set; req_ready=0 when hold or none valid.
//   On handshake of requester g: next cycle tree_vec/tree_beta register g's data.
//     Pointer <- (g+1) mod NREQ. Pointer unchanged when no grant.
//     No handshake: tree_vec/tree_beta hold the last value (a zero-input is not required; the tag marks validity).
//   Tag pipe: TREE_LAT-deep shift of {valid,id}. Stage 0 loads at the same edge as tree_vec.
//     res_valid/res_id = last stage; res_data = tree_sum, registered together with them.
//     Issue at edge T -> res_valid high at edge T+TREE_LAT+1 (handshake-to-result = TREE_LAT+1 cycles).
//   Throughput: 1 vector/clk, back-to-back allowed; the tree never stalls.
//     No result backpressure: consumers must accept res_valid.
//   Arithmetic: none here; the tree wraps in two's complement at DW bits. The arbiter passes data unmodified.
//   busy = OR of all tag-pipe valid bits and the res_valid register.
//   sched_hold asserted while req_valid high: requester waits, no data lost. Deassert -> grant next cycle from current ptr.
//   Requester may drop req_valid before ready (no commitment). Data must be stable only in the handshake cycle.
//   Single requester always valid: granted every cycle. All requesters valid: strict rotation 0,1,2,3,0,...
// CONFIGURATION
//   ADDER_ARB_PERF_EN defined:
//     adds out perf_grants  NREQ*16  per-requester saturating grant counters.
//     adds out perf_busy    16       count of cycles with busy=1, saturating.
//     Adds in perf_clr 1: synchronous clear. Reset -> 0.
//   Undefined: these ports and the counters do not exist; function otherwise identical.
// STRUCTURE
//   Package adder_tree_pkg: DW, NTERMS, TREE_LAT constants; tag_t {valid, id} typedef; clog2 function.
//   Sub-module rr_arbiter (NREQ): req, ptr in -> one-hot gnt, gnt_idx out; purely combinational.
//     Pointer register stays in the parent.
//   Parent: pointer, data mux + issue registers, tag shift pipe, result registers, optional perf counters.
// TESTING (bench includes a behavioural TREE_LAT-cycle sum model or the real tree)
//   Reset mid-stream, then 3 vectors issued and GlobalReset pulsed at cycle 4 -> no res_valid for 20 cycles after release; all outputs 0.
//   Req1 only, all terms 26'h0000100, beta 26'h0000040 -> req_ready[1] 1 cycle.
//     11 cycles later: res_valid=1, res_id=1, res_data=26'h0001C40.
//   All 4 valid for 8 cycles, data term=id+1 -> grant order 0,1,2,3,0,1,2,3.
//     Results in the same order, IDs tagged correctly, res_data=28*(id+1), beta=0.
//   sched_hold=1 for 5 cycles with req_valid=4'b1010 -> req_ready=0 throughout.
//     On release, grants 1 then 3, ptr=0 initially.
//   Overflow: all terms 26'h1FFFFFF (max positive), beta=0 -> res_data equals 2's-complement wrap of 28*(2^25-1) mod 2^26, i.e. 26'h3FFFFE4.
//   ADDER_ARB_PERF_EN: 100 grants to req2 -> perf_grants[2]=100.
//     perf_clr -> all 0; 70000 grants -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/adder_tree_arbiter_pkg.sv
// Shared constants and tag type for the adder-tree arbiter slice.
package adder_tree_pkg;

  localparam int DW       = 26;
  localparam int NTERMS   = 28;
  localparam int TREE_LAT = 10;
  localparam int MAX_IDW  = 3;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_arbiter_if.sv
// Requester, adder-tree and result bundle; slave is the arbiter's view.
interface adder_tree_arbiter_if #(
  parameter int NREQ = 4
);
  import adder_tree_pkg::*;

  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*NTERMS*DW-1:0] req_vec;
  logic [NREQ*DW-1:0]     req_beta;
  logic                   sched_hold;
  logic [NTERMS*DW-1:0]   tree_vec;
  logic [DW-1:0]          tree_beta;
  logic [DW-1:0]          tree_sum;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic [DW-1:0]          res_data;
  logic                   busy;

  modport slave (
    input  req_valid, req_vec, req_beta, sched_hold, tree_sum,
    output req_ready, tree_vec, tree_beta, res_valid, res_id, res_data, busy
  );

  modport master (
    output req_valid, req_vec, req_beta, sched_hold, tree_sum,
    input  req_ready, tree_vec, tree_beta, res_valid, res_id, res_data, busy
  );

endinterface

// File: rtl/adder_tree_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  int   idx_s;
  logic found_s;
  logic hit_s;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    gnt_idx = {IDW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s      = (int'(ptr) + i) % NREQ;
      hit_s      = !found_s && req[idx_s];
      gnt[idx_s] = gnt[idx_s] | hit_s;
      gnt_idx    = hit_s ? IDW'(idx_s) : gnt_idx;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one pipelined adder tree among NREQ requesters; results return tagged with their owner.
// Optional per-requester and busy perf counters under ADDER_ARB_PERF_EN.
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                GlobalReset,
  adder_tree_arbiter_if.slave bus
`ifdef ADDER_ARB_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [NREQ*16-1:0]  perf_grants,
  output logic [15:0]         perf_busy
`endif
);

  localparam int IDW = clog2(NREQ);
  localparam int VW  = NTERMS * DW;

  logic [NREQ-1:0] req_s;
  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic [IDW-1:0]  ptr_nxt_s;
  logic            hs_s;
  logic            busy_s;

  logic [IDW-1:0]  ptr_r;
  logic [VW-1:0]   tree_vec_r;
  logic [DW-1:0]   tree_beta_r;
  tag_t            tag_r [TREE_LAT];
  logic            res_valid_r;
  logic [IDW-1:0]  res_id_r;
  logic [DW-1:0]   res_data_r;

  assign req_s = bus.req_valid & {NREQ{~bus.sched_hold}};

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_s),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign hs_s      = |gnt_s;
  assign ptr_nxt_s = (int'(gnt_idx_s) == NREQ - 1) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1'b1);

  // Issue registers: capture the granted vector; without a grant the tree input simply holds.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      ptr_r       <= {IDW{1'b0}};
      tree_vec_r  <= {VW{1'b0}};
      tree_beta_r <= {DW{1'b0}};
    end else if (hs_s) begin
      ptr_r       <= ptr_nxt_s;
      tree_vec_r  <= bus.req_vec[int'(gnt_idx_s)*VW +: VW];
      tree_beta_r <= bus.req_beta[int'(gnt_idx_s)*DW +: DW];
    end
  end

  // Tag pipe tracks {valid,id} alongside the tree latency.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int i = 0; i < TREE_LAT; i++) tag_r[i] <= '{valid: 1'b0, id: {MAX_IDW{1'b0}}};
    end else begin
      tag_r[0] <= '{valid: hs_s, id: MAX_IDW'(gnt_idx_s)};
      for (int i = 1; i < TREE_LAT; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  // Result registers; res_id/res_data keep the last delivered result between strobes.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      res_valid_r <= 1'b0;
      res_id_r    <= {IDW{1'b0}};
      res_data_r  <= {DW{1'b0}};
    end else begin
      res_valid_r <= tag_r[TREE_LAT-1].valid;
      if (tag_r[TREE_LAT-1].valid) begin
        res_id_r   <= IDW'(tag_r[TREE_LAT-1].id);
        res_data_r <= bus.tree_sum;
      end
    end
  end

  // Busy while any tag is in flight or a result is being presented.
  always_comb begin
    busy_s = res_valid_r;
    for (int i = 0; i < TREE_LAT; i++) busy_s = busy_s | tag_r[i].valid;
  end

  assign bus.req_ready = gnt_s;
  assign bus.tree_vec  = tree_vec_r;
  assign bus.tree_beta = tree_beta_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_id    = res_id_r;
  assign bus.res_data  = res_data_r;
  assign bus.busy      = busy_s;

`ifdef ADDER_ARB_PERF_EN
  logic [15:0] grant_cnt_r [NREQ];
  logic [15:0] busy_cnt_r;

  // Saturating grant and busy-cycle counters with synchronous clear.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int i = 0; i < NREQ; i++) grant_cnt_r[i] <= 16'd0;
      busy_cnt_r <= 16'd0;
    end else if (perf_clr) begin
      for (int i = 0; i < NREQ; i++) grant_cnt_r[i] <= 16'd0;
      busy_cnt_r <= 16'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_s[i] && (grant_cnt_r[i] != 16'hFFFF)) grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
      end
      if (busy_s && (busy_cnt_r != 16'hFFFF)) busy_cnt_r <= busy_cnt_r + 16'd1;
    end
  end

  always_comb begin
    perf_grants = {(NREQ*16){1'b0}};
    for (int i = 0; i < NREQ; i++) perf_grants[i*16 +: 16] = grant_cnt_r[i];
  end

  assign perf_busy = busy_cnt_r;
`else
  // Counters absent in this build; datapath is unchanged.
`endif

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Directed bench: round-robin grant model, behavioural adder tree, result scoreboard.
module tb_adder_tree_arbiter;
  import adder_tree_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int VW   = NTERMS * DW;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic GlobalReset;
  always #5 clk = ~clk;

  adder_tree_arbiter_if #(.NREQ(NREQ)) bus();

`ifdef ADDER_ARB_PERF_EN
  logic                 perf_clr;
  logic [NREQ*16-1:0]   perf_grants;
  logic [15:0]          perf_busy;
  adder_tree_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus),
    .perf_clr(perf_clr), .perf_grants(perf_grants), .perf_busy(perf_busy)
  );
`else
  adder_tree_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus)
  );
`endif

  logic [DW-1:0] terms [NREQ][NTERMS];
  logic [DW-1:0] betas [NREQ];
  logic [DW-1:0] tpipe [TREE_LAT-1];
  exp_t          sbq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mptr = 0;

  always_comb begin
    bus.req_vec  = '0;
    bus.req_beta = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_beta[i*DW +: DW] = betas[i];
      for (int t = 0; t < NTERMS; t++) bus.req_vec[(i*NTERMS+t)*DW +: DW] = terms[i][t];
    end
  end

  function automatic logic [DW-1:0] vec_sum(input logic [VW-1:0] v, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    s = b;
    for (int t = 0; t < NTERMS; t++) s = s + v[t*DW +: DW];
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_sum(input int id);
    logic [DW-1:0] s;
    s = betas[id];
    for (int t = 0; t < NTERMS; t++) s = s + terms[id][t];
    return s;
  endfunction

  // Behavioural tree: the sum leaves TREE_LAT cycles after the issue edge that loaded tree_vec.
  always @(posedge clk) begin
    tpipe[0] <= vec_sum(bus.tree_vec, bus.tree_beta);
    for (int k = 1; k < TREE_LAT - 1; k++) tpipe[k] <= tpipe[k-1];
  end
  assign bus.tree_sum = tpipe[TREE_LAT-2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result strobe must match the oldest outstanding issue, on its due cycle.
  always @(negedge clk) begin
    if (!GlobalReset && bus.res_valid === 1'b1) begin
      chk("res_expected", VW'(sbq.size() != 0), VW'(1));
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("res_id", VW'(bus.res_id), VW'(e.id));
        chk("res_data", VW'(bus.res_data), VW'(e.data));
        chk("res_cycle", VW'(cyc), VW'(e.due));
      end
    end
  end

  task automatic step(input logic [NREQ-1:0] v, input logic h);
    logic [NREQ-1:0] eg;
    int g;
    exp_t e;
    bus.req_valid  = v;
    bus.sched_hold = h;
    eg = '0;
    g  = -1;
    if (!h) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g < 0 && v[(mptr + i) % NREQ]) g = (mptr + i) % NREQ;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    @(negedge clk);
    chk("req_ready", VW'(bus.req_ready), VW'(eg));
    if (g >= 0) begin
      e.id   = IDW'(g);
      e.data = exp_sum(g);
      e.due  = cyc + TREE_LAT + 1;
      sbq.push_back(e);
      mptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step('0, 1'b0);
    chk("scoreboard_empty", VW'(sbq.size()), VW'(0));
    chk("busy_idle", VW'(bus.busy), VW'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, VW'(bus.req_ready), VW'(0));
    chk({tag, "_tree_vec"}, bus.tree_vec, VW'(0));
    chk({tag, "_tree_beta"}, VW'(bus.tree_beta), VW'(0));
    chk({tag, "_res_valid"}, VW'(bus.res_valid), VW'(0));
    chk({tag, "_res_id"}, VW'(bus.res_id), VW'(0));
    chk({tag, "_res_data"}, VW'(bus.res_data), VW'(0));
    chk({tag, "_busy"}, VW'(bus.busy), VW'(0));
  endtask

  task automatic set_data(input int id, input logic [DW-1:0] term, input logic [DW-1:0] beta);
    for (int t = 0; t < NTERMS; t++) terms[id][t] = term;
    betas[id] = beta;
  endtask

  initial begin
    GlobalReset    = 1'b1;
    bus.req_valid  = '0;
    bus.sched_hold = 1'b0;
`ifdef ADDER_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) set_data(i, DW'(0), DW'(0));
    repeat (3) @(posedge clk);
    #1 GlobalReset = 1'b0;
    check_zero("reset");

    // Three issues in flight, then an asynchronous reset drops them all.
    for (int i = 0; i < NREQ; i++) set_data(i, DW'(i + 5), DW'(1));
    repeat (3) step(4'b0111, 1'b0);
    step('0, 1'b0);
    GlobalReset = 1'b1;
    sbq.delete();
    mptr = 0;
    #1 check_zero("mid_reset");
    @(posedge clk);
    #1 GlobalReset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("no_res_after_reset", VW'(bus.res_valid), VW'(0));
    end
    @(posedge clk);
    #1 check_zero("post_reset");

    // All requesters valid: strict rotation, term = id+1.
    for (int i = 0; i < NREQ; i++) set_data(i, DW'(i + 1), DW'(0));
    repeat (8) step(4'b1111, 1'b0);
    drain(14);

    // Single requester 1.
    set_data(1, 26'h0000100, 26'h0000040);
    step(4'b0010, 1'b0);
    drain(13);

    // Move the pointer to 0, then hold with 1010 pending.
    step(4'b1000, 1'b0);
    repeat (5) step(4'b1010, 1'b1);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    drain(13);

    // Lone requester is granted back-to-back; then two's-complement wrap of the tree.
    set_data(0, 26'h1FFFFFF, 26'h0000000);
    repeat (4) step(4'b0001, 1'b0);
    drain(13);
    chk("wrap_model", VW'(exp_sum(0)), VW'(26'h3FFFFE4));

`ifdef ADDER_ARB_PERF_EN
    perf_clr = 1'b1;
    @(posedge clk);
    #1 perf_clr = 1'b0;
    chk("perf_clr_grants", VW'(perf_grants), VW'(0));
    set_data(2, DW'(3), DW'(7));
    repeat (100) step(4'b0100, 1'b0);
    chk("perf_grants2_100", VW'(perf_grants[2*16 +: 16]), VW'(100));
    chk("perf_grants0_0", VW'(perf_grants[0 +: 16]), VW'(0));
    perf_clr = 1'b1;
    @(posedge clk);
    #1 perf_clr = 1'b0;
    chk("perf_clr2_grants", VW'(perf_grants), VW'(0));
    chk("perf_clr2_busy", VW'(perf_busy), VW'(0));
    repeat (70000) step(4'b0100, 1'b0);
    chk("perf_grants2_sat", VW'(perf_grants[2*16 +: 16]), VW'(16'hFFFF));
    chk("perf_busy_sat", VW'(perf_busy), VW'(16'hFFFF));
    drain(13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
